alu_pipe: RTL and testbench
===========================

Name: alu_pipe

Overview:
Parametrised two-stage pipelined ALU. It succeeds the single-cycle, enable-loaded ALU in the TP datapath.
- Accepts operand A, operand B and a 6-bit function code as one transaction on a valid/ready input handshake.
- Returns result plus carry/zero/negative/overflow/error flags on a valid/ready output handshake.
- Full throughput: one op per cycle. Fixed latency of 2 cycles. Sits between the operand source (UART/switch front-end or decode stage) and the result consumer.

Parameters:
NB_DATA, 8, operand/result width (>=4, power of 2)
NB_OP, 6, function-code width
NB_SHAMT, $clog2(NB_DATA), shift-amount width (derived; not overridden)
NB_CNT, 16, width of completed-operation counter

Ports:
i_clk  in  1  clock, rising edge
i_reset_n  in  1  asynchronous active-low reset
i_valid  in  1  input transaction valid
o_ready  out  1  block can accept input this cycle
i_data_a  in  NB_DATA  operand A
i_data_b  in  NB_DATA  operand B (shift amount = i_data_b[NB_SHAMT-1:0])
i_op  in  NB_OP  function code
o_valid  out  1  result valid
i_ready  in  1  consumer accepts result this cycle
o_data  out  NB_DATA  result
o_carry  out  1  carry-out (ADD) / borrow (SUB), else 0
o_zero  out  1  o_data == 0
o_neg  out  1  o_data[NB_DATA-1]
o_ovf  out  1  signed overflow (ADD/SUB), else 0
o_err  out  1  illegal function code
o_op_count  out  NB_CNT  number of results consumed since reset

Behaviour:
- Reset: when i_reset_n is low, all state clears immediately (asynchronous). Clears both stage-valid bits, o_valid, o_data, all flags and o_op_count. o_ready=1 during and after reset. Reset mid-operation discards in-flight ops; nothing is replayed.
- Handshake:
  - Input is accepted on i_valid & o_ready.
  - Output is transferred on o_valid & i_ready.
  - Once o_valid is asserted, o_data and all flags hold stable until transfer.
- Pipeline:
  - S1 registers {a, b, op} with a valid bit s1_v.
  - S2 computes combinationally from S1 and registers the result and flags. o_valid = s2_v.
- Advance rules:
  - adv2 = s1_v & (!s2_v | i_ready)
  - o_ready = !s1_v | adv2
  - These allow full throughput and 2-deep buffering under backpressure. No combinational path from i_valid to o_ready; o_ready depends only on state and i_ready.
- Latency: an input accepted in cycle N appears with o_valid=1 in cycle N+2 when i_ready stays high. Strict FIFO order.
- Ops (NB_OP=6 codes):
  - 100000 ADD: {c,r}=a+b.
  - 100010 SUB: {c,r}={0,a}-{0,b}; c=1 iff a<b unsigned.
  - 100100 AND.
  - 100101 OR.
  - 100110 XOR.
  - 100111 NOR.
  - 101010 SLT: r=1 if signed a<b, else 0.
  - 101011 SLTU: r=1 if unsigned a<b, else 0.
  - 000000 SLL: a<<shamt.
  - 000010 SRL: logical a>>shamt.
  - 000011 SRA: arithmetic a>>>shamt, sign-filled.
- Overflow:
  - ADD: ovf = (a[msb]==b[msb]) & (r[msb]!=a[msb]).
  - SUB: ovf = (a[msb]!=b[msb]) & (r[msb]!=a[msb]).
  - All other ops: 0.
- Illegal code: r=0, carry=ovf=0, err=1. zero=1 and neg=0 follow from r. The transaction still flows through the pipeline normally.
- o_zero and o_neg are always derived from the registered result.
- o_op_count increments on each output transfer and wraps modulo 2^NB_CNT.
- Simultaneous input accept and output transfer in one cycle: both occur with no bubble.

Decomposition:
- Shared package alu_pkg: op-code localparams (OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SLT, OP_SLTU, OP_SLL, OP_SRL, OP_SRA) and a flag-bit index set (FLG_CARRY, FLG_ZERO, FLG_NEG, FLG_OVF, FLG_ERR).
- One sub-module, alu_core: purely combinational, parametrised NB_DATA/NB_OP. Maps (a, b, op) to (result, carry, ovf, err). alu_pipe instantiates it between S1 and S2 and owns all handshake and pipeline registers.

Test Plan:
- NB_DATA=8, i_ready=1. ADD a=0xFF, b=0x01 -> two cycles later: o_data=0x00, carry=1, zero=1, ovf=0, neg=0.
- SUB a=0x80, b=0x01 -> o_data=0x7F, carry=0, ovf=1, neg=0. SUB a=0x01, b=0x02 -> o_data=0xFF, carry=1, neg=1.
- Shifts, a=0x80, b=0x03: SRA -> 0xF0; SRL -> 0x10; SLL -> 0x00 with zero=1. SLT a=0xFE, b=0x01 -> 1; SLTU same operands -> 0.
- Backpressure:
  - Stimulus: i_ready=0, then four back-to-back ops.
  - Response: exactly 2 accepted; o_ready=0 from the cycle after the second accept; o_data stable while stalled. After i_ready=1, results emerge in order, one per cycle; o_op_count=4 at the end.
- Illegal op 6'b111111, a=0x12, b=0x34 -> o_data=0x00, err=1, zero=1, carry=0.
- Assert i_reset_n=0 asynchronously (between clock edges) with 2 ops in flight -> o_valid=0 and o_op_count=0 immediately. o_ready=1 after release; no stale result ever appears.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the pipelined ALU: function codes and flag-bit positions.
package alu_pkg;

  // Function codes (6-bit, MIPS R-type funct style)
  localparam logic [5:0] OP_ADD  = 6'b100000;
  localparam logic [5:0] OP_SUB  = 6'b100010;
  localparam logic [5:0] OP_AND  = 6'b100100;
  localparam logic [5:0] OP_OR   = 6'b100101;
  localparam logic [5:0] OP_XOR  = 6'b100110;
  localparam logic [5:0] OP_NOR  = 6'b100111;
  localparam logic [5:0] OP_SLT  = 6'b101010;
  localparam logic [5:0] OP_SLTU = 6'b101011;
  localparam logic [5:0] OP_SLL  = 6'b000000;
  localparam logic [5:0] OP_SRL  = 6'b000010;
  localparam logic [5:0] OP_SRA  = 6'b000011;

  // Bit positions inside the packed flag vector
  localparam int FLG_CARRY = 0;
  localparam int FLG_ZERO  = 1;
  localparam int FLG_NEG   = 2;
  localparam int FLG_OVF   = 3;
  localparam int FLG_ERR   = 4;
  localparam int NB_FLG    = 5;

endpackage

// File: rtl/alu_if.sv
// Valid/ready operand and result channels of the pipelined ALU.
// master = operand source / result consumer side, slave = ALU side.
interface alu_if #(
  parameter int NB_DATA = 8,
  parameter int NB_OP   = 6,
  parameter int NB_CNT  = 16
);
  // input channel
  logic               i_valid;
  logic               o_ready;
  logic [NB_DATA-1:0] i_data_a;
  logic [NB_DATA-1:0] i_data_b;
  logic [NB_OP-1:0]   i_op;
  // output channel
  logic               o_valid;
  logic               i_ready;
  logic [NB_DATA-1:0] o_data;
  logic               o_carry;
  logic               o_zero;
  logic               o_neg;
  logic               o_ovf;
  logic               o_err;
  logic [NB_CNT-1:0]  o_op_count;

  modport master (
    output i_valid, i_data_a, i_data_b, i_op, i_ready,
    input  o_ready, o_valid, o_data, o_carry, o_zero, o_neg, o_ovf, o_err, o_op_count
  );

  modport slave (
    input  i_valid, i_data_a, i_data_b, i_op, i_ready,
    output o_ready, o_valid, o_data, o_carry, o_zero, o_neg, o_ovf, o_err, o_op_count
  );
endinterface

// File: rtl/alu_core.sv
// Purely combinational ALU datapath: (a, b, op) -> (result, carry, ovf, err).
// Zero/negative are not produced here; the pipeline derives them from its
// registered result so they can never disagree with o_data.
module alu_core
  import alu_pkg::*;
#(
  parameter int NB_DATA = 8,
  parameter int NB_OP   = 6
) (
  input  logic [NB_DATA-1:0] a_i,
  input  logic [NB_DATA-1:0] b_i,
  input  logic [NB_OP-1:0]   op_i,
  output logic [NB_DATA-1:0] result_o,
  output logic               carry_o,
  output logic               ovf_o,
  output logic               err_o
);

  localparam int NB_SHAMT = $clog2(NB_DATA);
  localparam int MSB      = NB_DATA - 1;

  logic [NB_SHAMT-1:0] shamt;
  logic [NB_DATA:0]    sum;
  logic [NB_DATA:0]    diff;
  logic                lt_s;
  logic                lt_u;

  assign shamt = b_i[NB_SHAMT-1:0];
  // One extra bit captures carry-out for ADD and borrow for SUB
  assign sum   = {1'b0, a_i} + {1'b0, b_i};
  assign diff  = {1'b0, a_i} - {1'b0, b_i};
  assign lt_s  = $signed(a_i) < $signed(b_i);
  assign lt_u  = a_i < b_i;

  // Operation decode; unknown codes yield a zero result with err raised
  always_comb begin
    result_o = '0;
    carry_o  = 1'b0;
    ovf_o    = 1'b0;
    err_o    = 1'b0;
    case (op_i)
      OP_ADD: begin
        result_o = sum[NB_DATA-1:0];
        carry_o  = sum[NB_DATA];
        ovf_o    = (a_i[MSB] == b_i[MSB]) & (sum[MSB] != a_i[MSB]);
      end
      OP_SUB: begin
        result_o = diff[NB_DATA-1:0];
        carry_o  = diff[NB_DATA];
        ovf_o    = (a_i[MSB] != b_i[MSB]) & (diff[MSB] != a_i[MSB]);
      end
      OP_AND:  result_o = a_i & b_i;
      OP_OR:   result_o = a_i | b_i;
      OP_XOR:  result_o = a_i ^ b_i;
      OP_NOR:  result_o = ~(a_i | b_i);
      OP_SLT:  result_o = {{(NB_DATA-1){1'b0}}, lt_s};
      OP_SLTU: result_o = {{(NB_DATA-1){1'b0}}, lt_u};
      OP_SLL:  result_o = a_i << shamt;
      OP_SRL:  result_o = a_i >> shamt;
      OP_SRA:  result_o = $unsigned($signed(a_i) >>> shamt);
      default: err_o    = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with valid/ready on both sides.
// S1 registers the operands, S2 registers the result and flags. The S1 slot
// doubles as a skid buffer so the block keeps one op per cycle and buffers
// two ops under backpressure; o_ready never depends on i_valid.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int NB_DATA = 8,
  parameter int NB_OP   = 6,
  parameter int NB_CNT  = 16
) (
  input  logic i_clk,
  input  logic i_reset_n,
  alu_if.slave bus
);

  // Stage 1 state
  logic [NB_DATA-1:0] a_q,    a_d;
  logic [NB_DATA-1:0] b_q,    b_d;
  logic [NB_OP-1:0]   op_q,   op_d;
  logic               s1_v_q, s1_v_d;
  // Stage 2 state
  logic [NB_DATA-1:0] data_q,  data_d;
  logic               carry_q, carry_d;
  logic               ovf_q,   ovf_d;
  logic               err_q,   err_d;
  logic               s2_v_q,  s2_v_d;
  logic [NB_CNT-1:0]  cnt_q,   cnt_d;

  // Core outputs and handshake qualifiers
  logic [NB_DATA-1:0] core_result;
  logic               core_carry;
  logic               core_ovf;
  logic               core_err;
  logic               adv2;
  logic               accept;
  logic               xfer;
  logic               ready;
  logic [NB_FLG-1:0]  flags;

  alu_core #(
    .NB_DATA (NB_DATA),
    .NB_OP   (NB_OP)
  ) u_core (
    .a_i      (a_q),
    .b_i      (b_q),
    .op_i     (op_q),
    .result_o (core_result),
    .carry_o  (core_carry),
    .ovf_o    (core_ovf),
    .err_o    (core_err)
  );

  // S1 moves into S2 when S2 is empty or is being drained this cycle
  assign adv2   = s1_v_q & (~s2_v_q | bus.i_ready);
  assign ready  = ~s1_v_q | adv2;
  assign accept = bus.i_valid & ready;
  assign xfer   = s2_v_q & bus.i_ready;

  // Next-state for both stages and the completed-op counter
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    s1_v_d  = s1_v_q;
    data_d  = data_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    err_d   = err_q;
    s2_v_d  = s2_v_q;
    cnt_d   = cnt_q;

    if (accept) begin
      a_d    = bus.i_data_a;
      b_d    = bus.i_data_b;
      op_d   = bus.i_op;
      s1_v_d = 1'b1;
    end else if (adv2) begin
      s1_v_d = 1'b0;
    end

    // S2 only reloads on advance, so its contents hold while stalled
    if (adv2) begin
      data_d  = core_result;
      carry_d = core_carry;
      ovf_d   = core_ovf;
      err_d   = core_err;
      s2_v_d  = 1'b1;
    end else if (xfer) begin
      s2_v_d = 1'b0;
    end

    if (xfer) begin
      cnt_d = cnt_q + NB_CNT'(1);
    end
  end

  // Pipeline registers; reset drops in-flight ops immediately
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      s1_v_q  <= 1'b0;
      data_q  <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
      s2_v_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      s1_v_q  <= s1_v_d;
      data_q  <= data_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
      s2_v_q  <= s2_v_d;
      cnt_q   <= cnt_d;
    end
  end

  // Flag bundle; zero/neg come straight from the registered result
  always_comb begin
    flags            = '0;
    flags[FLG_CARRY] = carry_q;
    flags[FLG_ZERO]  = ~|data_q;
    flags[FLG_NEG]   = data_q[NB_DATA-1];
    flags[FLG_OVF]   = ovf_q;
    flags[FLG_ERR]   = err_q;
  end

  assign bus.o_ready    = ready;
  assign bus.o_valid    = s2_v_q;
  assign bus.o_data     = data_q;
  assign bus.o_carry    = flags[FLG_CARRY];
  assign bus.o_zero     = flags[FLG_ZERO];
  assign bus.o_neg      = flags[FLG_NEG];
  assign bus.o_ovf      = flags[FLG_OVF];
  assign bus.o_err      = flags[FLG_ERR];
  assign bus.o_op_count = cnt_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe: vector table streamed at full rate, then
// backpressure, illegal-op and asynchronous-reset sequences.
module tb_alu_pipe;
  import alu_pkg::*;

  localparam int NB_DATA = 8;
  localparam int NB_OP   = 6;
  localparam int NB_CNT  = 16;
  localparam int NV      = 18;

  typedef struct {
    logic [5:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] r;
    logic [4:0] flg;  // {carry, zero, neg, ovf, err}
  } vec_t;

  typedef struct {
    vec_t v;
    int   acc_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_if #(.NB_DATA(NB_DATA), .NB_OP(NB_OP), .NB_CNT(NB_CNT)) bus();

  alu_pipe #(.NB_DATA(NB_DATA), .NB_OP(NB_OP), .NB_CNT(NB_CNT)) u_dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .bus       (bus)
  );

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   lat_chk = 1'b0;
  bit   b2b_chk = 1'b0;
  int   prev_xfer = -1;
  exp_t sb_q[$];
  exp_t mon_e;
  vec_t vecs[NV];
  vec_t bp[4];

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic vec_t mkv(logic [5:0] op, logic [7:0] a, logic [7:0] b, logic [7:0] r,
                               logic c, logic z, logic n, logic v, logic e);
    vec_t t;
    t.op = op; t.a = a; t.b = b; t.r = r; t.flg = {c, z, n, v, e};
    return t;
  endfunction

  always @(posedge clk) cyc++;

  // Scoreboard: result at the head must be on the bus whenever o_valid is high
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.o_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("spurious_valid", 32'(bus.o_valid), 32'd0);
      end else begin
        mon_e = sb_q[0];
        chk($sformatf("data op=%b a=%h b=%h", mon_e.v.op, mon_e.v.a, mon_e.v.b),
            32'(bus.o_data), 32'(mon_e.v.r));
        chk($sformatf("flags(c,z,n,v,e) op=%b a=%h b=%h", mon_e.v.op, mon_e.v.a, mon_e.v.b),
            32'({bus.o_carry, bus.o_zero, bus.o_neg, bus.o_ovf, bus.o_err}), 32'(mon_e.v.flg));
        if (bus.i_ready === 1'b1) begin
          if (lat_chk) chk("latency", 32'(cyc - mon_e.acc_cyc), 32'd2);
          if (b2b_chk && prev_xfer >= 0) chk("back_to_back", 32'(cyc - prev_xfer), 32'd1);
          prev_xfer = cyc;
          void'(sb_q.pop_front());
        end
      end
    end
  end

  // Drive one op and hold it until accepted (bounded)
  task automatic send(input vec_t vec);
    bit ok;
    ok = 1'b0;
    bus.i_valid  = 1'b1;
    bus.i_data_a = vec.a;
    bus.i_data_b = vec.b;
    bus.i_op     = vec.op;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.o_ready === 1'b1) begin
        sb_q.push_back('{v: vec, acc_cyc: cyc});
        ok = 1'b1;
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
    end
    chk("accepted", 32'(ok), 32'd1);
    bus.i_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 30; i++) begin
      @(negedge clk); #1;
      if (sb_q.size() == 0) break;
    end
    chk("drain_empty", 32'(sb_q.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic apply_reset();
    @(posedge clk); #2;
    rst_n = 1'b0;
    sb_q.delete();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] illegal_op;
    illegal_op = 6'b111111;

    vecs[0]  = mkv(OP_ADD,  8'hFF, 8'h01, 8'h00, 1, 1, 0, 0, 0);
    vecs[1]  = mkv(OP_SUB,  8'h80, 8'h01, 8'h7F, 0, 0, 0, 1, 0);
    vecs[2]  = mkv(OP_SUB,  8'h01, 8'h02, 8'hFF, 1, 0, 1, 0, 0);
    vecs[3]  = mkv(OP_SRA,  8'h80, 8'h03, 8'hF0, 0, 0, 1, 0, 0);
    vecs[4]  = mkv(OP_SRL,  8'h80, 8'h03, 8'h10, 0, 0, 0, 0, 0);
    vecs[5]  = mkv(OP_SLL,  8'h80, 8'h03, 8'h00, 0, 1, 0, 0, 0);
    vecs[6]  = mkv(OP_SLT,  8'hFE, 8'h01, 8'h01, 0, 0, 0, 0, 0);
    vecs[7]  = mkv(OP_SLTU, 8'hFE, 8'h01, 8'h00, 0, 1, 0, 0, 0);
    vecs[8]  = mkv(illegal_op, 8'h12, 8'h34, 8'h00, 0, 1, 0, 0, 1);
    vecs[9]  = mkv(OP_ADD,  8'h7F, 8'h01, 8'h80, 0, 0, 1, 1, 0);
    vecs[10] = mkv(OP_AND,  8'hF0, 8'h3C, 8'h30, 0, 0, 0, 0, 0);
    vecs[11] = mkv(OP_OR,   8'hF0, 8'h0F, 8'hFF, 0, 0, 1, 0, 0);
    vecs[12] = mkv(OP_XOR,  8'hAA, 8'hFF, 8'h55, 0, 0, 0, 0, 0);
    vecs[13] = mkv(OP_NOR,  8'h0F, 8'hF0, 8'h00, 0, 1, 0, 0, 0);
    vecs[14] = mkv(OP_SLT,  8'h01, 8'hFE, 8'h00, 0, 1, 0, 0, 0);
    vecs[15] = mkv(OP_SRA,  8'h7F, 8'h09, 8'h3F, 0, 0, 0, 0, 0);
    vecs[16] = mkv(OP_SUB,  8'h05, 8'h05, 8'h00, 0, 1, 0, 0, 0);
    vecs[17] = mkv(OP_SLL,  8'h01, 8'h0F, 8'h80, 0, 0, 1, 0, 0);

    bp[0] = mkv(OP_ADD, 8'h01, 8'h02, 8'h03, 0, 0, 0, 0, 0);
    bp[1] = mkv(OP_SUB, 8'h10, 8'h01, 8'h0F, 0, 0, 0, 0, 0);
    bp[2] = mkv(OP_XOR, 8'h0F, 8'hF0, 8'hFF, 0, 0, 1, 0, 0);
    bp[3] = mkv(OP_AND, 8'hFF, 8'h0F, 8'h0F, 0, 0, 0, 0, 0);

    bus.i_valid  = 1'b0;
    bus.i_data_a = '0;
    bus.i_data_b = '0;
    bus.i_op     = '0;
    bus.i_ready  = 1'b1;
    rst_n        = 1'b1;

    // Reset state
    #2 rst_n = 1'b0;
    #1;
    chk("rst_o_valid", 32'(bus.o_valid), 32'd0);
    chk("rst_o_ready", 32'(bus.o_ready), 32'd1);
    chk("rst_o_data", 32'(bus.o_data), 32'd0);
    chk("rst_cov_err", 32'({bus.o_carry, bus.o_ovf, bus.o_err}), 32'd0);
    chk("rst_op_count", 32'(bus.o_op_count), 32'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_o_ready", 32'(bus.o_ready), 32'd1);
    chk("post_rst_o_valid", 32'(bus.o_valid), 32'd0);

    // Full-rate stream of the vector table, fixed 2-cycle latency
    lat_chk = 1'b1;
    b2b_chk = 1'b1;
    prev_xfer = -1;
    for (int i = 0; i < NV; i++) send(vecs[i]);
    drain();
    chk("stream_op_count", 32'(bus.o_op_count), 32'(NV));

    // Backpressure: only two ops fit, output holds, then drains in order
    apply_reset();
    chk("bp_rst_op_count", 32'(bus.o_op_count), 32'd0);
    lat_chk = 1'b0;
    bus.i_ready = 1'b0;
    send(bp[0]);
    send(bp[1]);
    bus.i_valid  = 1'b1;
    bus.i_data_a = bp[2].a;
    bus.i_data_b = bp[2].b;
    bus.i_op     = bp[2].op;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp_o_ready_low", 32'(bus.o_ready), 32'd0);
      @(posedge clk); #1;
    end
    chk("bp_accepted", 32'(sb_q.size()), 32'd2);
    prev_xfer = -1;
    bus.i_ready = 1'b1;
    send(bp[2]);
    send(bp[3]);
    drain();
    chk("bp_op_count", 32'(bus.o_op_count), 32'd4);

    // Asynchronous reset with two ops in flight
    lat_chk = 1'b1;
    prev_xfer = -1;
    send(vecs[0]);
    send(vecs[1]);
    chk("inflight_o_valid", 32'(bus.o_valid), 32'd1);
    #1 rst_n = 1'b0;
    sb_q.delete();
    #1;
    chk("async_rst_o_valid", 32'(bus.o_valid), 32'd0);
    chk("async_rst_op_count", 32'(bus.o_op_count), 32'd0);
    chk("async_rst_o_ready", 32'(bus.o_ready), 32'd1);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("no_stale_o_valid", 32'(bus.o_valid), 32'd0);
      chk("post_async_o_ready", 32'(bus.o_ready), 32'd1);
    end
    @(posedge clk); #1;
    prev_xfer = -1;
    send(vecs[6]);
    drain();
    chk("final_op_count", 32'(bus.o_op_count), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
